// File: rtl/i2c_pkg.sv
// i2c_pkg: command encoding, FSM state and phase types shared by the I2C
// sequencer and the byte master.
package i2c_pkg;
    localparam int ADDR_W = 7;
    typedef enum logic [3:0] {
        CMD_IDLE    = 4'd0,
        CMD_START   = 4'd1,
        CMD_STOP    = 4'd2,
        CMD_RESTART = 4'd3,
        CMD_RD      = 4'd4,
        CMD_WR      = 4'd5
    } cmd_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_WAIT_RDY
    } seq_state_e;
    typedef enum logic [1:0] {
        PH_START,
        PH_ADDR,
        PH_DATA,
        PH_STOP
    } phase_e;
endpackage

// File: rtl/i2c_seq_watchdog.sv
// i2c_seq_watchdog: per-state cycle counter that flags a stuck master handshake.
// Only instantiated by the sequencer when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_seq_watchdog #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) r_cnt <= '0;
        else r_cnt <= (!i_run || i_clr) ? '0 : r_cnt + CW'(1);
    assign o_expire = i_run && (r_cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one host transaction into the byte master's START/WR/RD/STOP stream.
// Optional handshake watchdog and sticky err flag enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 200000
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_slv_addr,
    input  logic [LEN_W-1:0]  i_byte_cnt,
    input  logic [7:0]        i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [3:0]        o_cmd,
    output logic [7:0]        o_m_tx_data,
    input  logic [7:0]        i_m_rx_data,
    input  logic              i_m_ready,
    input  logic              i_m_tx_done,
    input  logic              i_m_rx_done
);
    seq_state_e        r_state, w_fsm_nxt;
    phase_e            r_phase, w_phase_nxt;
    cmd_e              r_cmd, w_issue_cmd;
    logic              r_rw, r_lvl_d, r_wr_ready, r_rd_valid, r_busy, r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic [7:0]        r_tx_data, r_rd_data;
    logic              w_accept, w_issue, w_rise, w_timeout, w_wr_stall;

    assign w_accept   = (r_state == S_IDLE) && i_start && i_m_ready;
    assign w_rise     = (i_m_tx_done | i_m_rx_done) & ~r_lvl_d;
    assign w_wr_stall = (r_phase == PH_DATA) && !r_rw && !i_wr_valid;

    always_comb begin
        w_fsm_nxt   = r_state;
        w_issue     = 1'b0;
        w_issue_cmd = r_phase == PH_START ? CMD_START :
                      r_phase == PH_STOP  ? CMD_STOP  :
                      (r_phase == PH_DATA && r_rw) ? CMD_RD : CMD_WR;
        w_phase_nxt = r_phase == PH_START ? PH_ADDR : (r_cnt == '0) ? PH_STOP : PH_DATA;
        case (r_state)
            S_IDLE:      if (w_accept) w_fsm_nxt = S_ISSUE;
            S_ISSUE: begin
                w_issue = !w_wr_stall;
                if (w_issue) w_fsm_nxt = S_WAIT_ACC;
            end
            S_WAIT_ACC:  if (!i_m_ready)
                             w_fsm_nxt = (r_phase == PH_START || r_phase == PH_STOP) ? S_WAIT_RDY : S_WAIT_DONE;
            S_WAIT_DONE: if (w_rise) w_fsm_nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (i_m_ready) w_fsm_nxt = (r_phase == PH_STOP) ? S_IDLE : S_ISSUE;
            default:     w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_phase    <= PH_START;
            r_cmd      <= CMD_IDLE;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_rd_data  <= '0;
            r_lvl_d    <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_timeout ? S_IDLE : w_fsm_nxt;
            r_lvl_d    <= i_m_tx_done | i_m_rx_done;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_accept) begin
                r_rw    <= i_rw;
                r_addr  <= i_slv_addr;
                r_cnt   <= i_byte_cnt;
                r_phase <= PH_START;
                r_busy  <= 1'b1;
            end
            if (w_issue) begin
                r_cmd <= w_issue_cmd;
                if (r_phase == PH_ADDR) r_tx_data <= {r_addr, r_rw};
                if (r_phase == PH_DATA) begin
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (!r_rw) begin
                        r_tx_data  <= i_wr_data;
                        r_wr_ready <= 1'b1;
                    end
                end
            end
            if (r_state == S_WAIT_ACC && !i_m_ready) r_cmd <= CMD_IDLE;
            if (r_state == S_WAIT_DONE && w_rise && r_rw && r_phase == PH_DATA) begin
                r_rd_data  <= i_m_rx_data;
                r_rd_valid <= 1'b1;
            end
            if (r_state == S_WAIT_RDY && i_m_ready) begin
                if (r_phase == PH_STOP) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else r_phase <= w_phase_nxt;
            end
            if (w_timeout) begin
                r_cmd  <= CMD_IDLE;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end

`ifdef I2C_SEQ_TIMEOUT_EN
    logic r_err;
    i2c_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_run    (r_state == S_WAIT_ACC || r_state == S_WAIT_DONE || r_state == S_WAIT_RDY),
        .i_clr    (w_fsm_nxt != r_state),
        .o_expire (w_timeout)
    );
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) r_err <= 1'b0;
        else r_err <= w_timeout ? 1'b1 : w_accept ? 1'b0 : r_err;
    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // Drop the command in the same cycle the master shows it has taken it.
    assign o_cmd       = (r_state == S_WAIT_ACC && !i_m_ready) ? CMD_IDLE : r_cmd;
    assign o_m_tx_data = r_tx_data;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_wr_ready  = r_wr_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
endmodule
